// File: rtl/leitor_botoes.sv
// Button reader: 2-FF sync, debounce FSM, one accepted one-hot press per push with single-cycle strobes.
// Optional auto-repeat while a one-hot button is held: define LEITOR_BOTOES_AUTOREPEAT_EN.
module leitor_botoes #(
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int REPEAT_CICLOS   = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilita,
    input  logic [3:0] botoes,
    output logic [3:0] jogada,
    output logic       tem_jogada,
    output logic       jogada_invalida,
    output logic [2:0] db_estado
);
    localparam int MAX_CICLOS = (DEBOUNCE_CICLOS > REPEAT_CICLOS) ? DEBOUNCE_CICLOS : REPEAT_CICLOS;
    localparam int CW = $clog2(MAX_CICLOS) + 1;
    localparam logic [CW-1:0] DB_FIM = CW'(DEBOUNCE_CICLOS - 1);
`ifdef LEITOR_BOTOES_AUTOREPEAT_EN
    localparam logic [CW-1:0] RP_FIM = CW'(REPEAT_CICLOS - 1);
`endif

    typedef enum logic [2:0] {
        ESPERA        = 3'd0,
        FILTRA        = 3'd1,
        REGISTRA      = 3'd2,
        ESPERA_SOLTAR = 3'd3,
        FILTRA_SOLTAR = 3'd4
    } estado_t;

    estado_t       estado, prox;
    logic [3:0]    b_m, b_s, amostra;
    logic [CW-1:0] cnt, cnt_sat;
    logic          um_quente;

    assign um_quente = $onehot(amostra);
    assign cnt_sat   = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            b_m <= 4'd0;
            b_s <= 4'd0;
        end else begin
            b_m <= botoes;
            b_s <= b_m;
        end
    end

    always_comb begin
        prox = estado;
        case (estado)
            ESPERA:
                if (habilita && b_s != 4'd0) prox = FILTRA;
            FILTRA:
                // a glitch or loss of habilita wins over a counter that just completed
                if (b_s != amostra || !habilita) prox = ESPERA;
                else if (cnt == DB_FIM)          prox = REGISTRA;
            REGISTRA:
                prox = ESPERA_SOLTAR;
            ESPERA_SOLTAR:
                if (b_s == 4'd0) prox = FILTRA_SOLTAR;
`ifdef LEITOR_BOTOES_AUTOREPEAT_EN
                else if (b_s == amostra && um_quente && cnt == RP_FIM) prox = REGISTRA;
`endif
            FILTRA_SOLTAR:
                if (b_s != 4'd0)        prox = ESPERA_SOLTAR;
                else if (cnt == DB_FIM) prox = ESPERA;
            default:
                prox = ESPERA_SOLTAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= ESPERA_SOLTAR;
            cnt     <= '0;
            amostra <= 4'd0;
            jogada  <= 4'd0;
        end else begin
            estado <= prox;
            if (prox != estado)
                cnt <= '0;
            else if (estado == FILTRA || estado == FILTRA_SOLTAR)
                cnt <= cnt_sat;
`ifdef LEITOR_BOTOES_AUTOREPEAT_EN
            else if (estado == ESPERA_SOLTAR)
                cnt <= (b_s == amostra && um_quente) ? cnt_sat : '0;
`endif
            if (estado == ESPERA && prox == FILTRA)
                amostra <= b_s;
            // jogada is valid in the same cycle the strobe is decoded
            if (prox == REGISTRA && estado != REGISTRA && um_quente)
                jogada <= amostra;
        end
    end

    assign tem_jogada      = (estado == REGISTRA) && um_quente;
    assign jogada_invalida = (estado == REGISTRA) && !um_quente;
    assign db_estado       = estado;
endmodule

// File: tb/tb_leitor_botoes.sv
// Randomized and directed bench for leitor_botoes against a run-length reference model.
module tb_leitor_botoes;
    localparam int D = 4;
    localparam int R = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       habilita = 1'b1;
    logic [3:0] botoes = 4'd0;
    logic [3:0] jogada;
    logic       tem_jogada, jogada_invalida;
    logic [2:0] db_estado;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    leitor_botoes #(.DEBOUNCE_CICLOS(D), .REPEAT_CICLOS(R)) dut (
        .clock(clock), .reset(reset), .habilita(habilita), .botoes(botoes),
        .jogada(jogada), .tem_jogada(tem_jogada), .jogada_invalida(jogada_invalida),
        .db_estado(db_estado)
    );

    // Reference: a press is accepted once armed and the synchronized buttons held the same
    // nonzero value with habilita for D+1 consecutive samples; re-arming needs D+1 zero samples.
    typedef enum {P_PRESS, P_HIT, P_REL} fase_t;
    fase_t      fase;
    int         run, rep;
    logic [3:0] sync1, sync2, samp, m_jog;
    logic       m_tem, m_inv;

    task automatic model_step();
        logic [3:0] s;
        s = sync2;
        if (reset) begin
            fase = P_REL; run = 0; rep = 0; samp = 4'd0; m_jog = 4'd0;
            m_tem = 1'b0; m_inv = 1'b0;
        end else begin
            m_tem = 1'b0; m_inv = 1'b0;
            case (fase)
                P_PRESS:
                    if (run > 0) begin
                        if (habilita && s == samp) begin
                            run++;
                            if (run == D + 1) begin
                                fase = P_HIT;
                                if ($onehot(samp)) begin m_jog = samp; m_tem = 1'b1; end
                                else m_inv = 1'b1;
                            end
                        end else run = 0;
                    end else if (habilita && s != 4'd0) begin
                        samp = s; run = 1;
                    end
                P_HIT: begin fase = P_REL; run = 0; rep = 0; end
                default:
                    if (run > 0) begin
                        if (s == 4'd0) begin
                            run++;
                            if (run == D + 1) begin fase = P_PRESS; run = 0; end
                        end else begin run = 0; rep = 0; end
                    end else if (s == 4'd0) begin
                        run = 1; rep = 0;
                    end
`ifdef LEITOR_BOTOES_AUTOREPEAT_EN
                    else if (s == samp && $onehot(samp)) begin
                        rep++;
                        if (rep == R) begin fase = P_HIT; m_tem = 1'b1; m_jog = samp; rep = 0; end
                    end else rep = 0;
`endif
            endcase
        end
        sync2 = reset ? 4'd0 : sync1;
        sync1 = reset ? 4'd0 : botoes;
    endtask

    task automatic cyc(input logic [3:0] b);
        botoes = b;
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(4'd0);
    endtask

    function automatic bit rep_hit(input int i);
`ifdef LEITOR_BOTOES_AUTOREPEAT_EN
        return (i >= D + 2) && ((i - (D + 2)) % (R + 1) == 0);
`else
        return i == D + 2;
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cyc(4'd0);
        checks++;
        if ({jogada, tem_jogada, jogada_invalida, db_estado} !== {4'd0, 1'b0, 1'b0, 3'd3}) begin
            errors++;
            $display("FAIL reset_state: got jog=%b tem=%b inv=%b st=%0d want 0000 0 0 3",
                     jogada, tem_jogada, jogada_invalida, db_estado);
        end
    endtask

    task automatic test_held_through_reset();
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            reset = (i < 3);
            cyc(4'b0001);
            n += tem_jogada;
            checks++;
            if ({tem_jogada, jogada_invalida, jogada} !== {m_tem, m_inv, m_jog}) begin
                errors++;
                $display("FAIL held_reset cyc %0d: got %b%b %b want %b%b %b", i,
                         tem_jogada, jogada_invalida, jogada, m_tem, m_inv, m_jog);
            end
        end
        checks++;
        if (n != 0) begin errors++; $display("FAIL held_reset_nostrobe: got %0d want 0", n); end
        idle(10);
        n = 0;
        for (int i = 0; i < 12; i++) begin cyc(4'b0001); n += tem_jogada; end
        checks++;
        if (n != 1 || jogada !== 4'b0001) begin
            errors++;
            $display("FAIL repress: got strobes=%0d jog=%b want 1 0001", n, jogada);
        end
        idle(10);
    endtask

    task automatic test_press_latency();
        for (int i = 0; i < 30; i++) begin
            cyc(4'b0100);
            checks++;
            if (tem_jogada !== rep_hit(i) || jogada_invalida !== 1'b0) begin
                errors++;
                $display("FAIL latency cyc %0d: got tem=%b inv=%b want tem=%b inv=0", i,
                         tem_jogada, jogada_invalida, rep_hit(i));
            end
        end
        checks++;
        if (jogada !== 4'b0100 || db_estado !== 3'd3) begin
            errors++;
            $display("FAIL latency_after: got jog=%b st=%0d want 0100 3", jogada, db_estado);
        end
        idle(10);
    endtask

    task automatic test_glitch();
        int n;
        n = 0;
        for (int i = 0; i < 13; i++) begin
            cyc(i < 3 ? 4'b0010 : 4'b0000);
            n += tem_jogada + jogada_invalida;
        end
        checks++;
        if (n != 0 || jogada !== 4'b0100) begin
            errors++;
            $display("FAIL glitch: got strobes=%0d jog=%b want 0 0100", n, jogada);
        end
    endtask

    task automatic test_multi();
        int nt, ni;
        nt = 0; ni = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0011);
            nt += tem_jogada; ni += jogada_invalida;
            checks++;
            if (tem_jogada && jogada_invalida) begin
                errors++;
                $display("FAIL multi_both cyc %0d: got both strobes want at most one", i);
            end
        end
        checks++;
        if (nt != 0 || ni != 1 || jogada !== 4'b0100) begin
            errors++;
            $display("FAIL multi: got tem=%0d inv=%0d jog=%b want 0 1 0100", nt, ni, jogada);
        end
        idle(10);
    endtask

    task automatic test_habilita();
        int n;
        n = 0;
        habilita = 1'b0;
        for (int i = 0; i < 20; i++) begin cyc(4'b1000); n += tem_jogada; end
        idle(10);
        checks++;
        if (n != 0) begin errors++; $display("FAIL hab_off: got strobes=%0d want 0", n); end
        habilita = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin cyc(4'b1000); n += tem_jogada; end
        checks++;
        if (n != 1 || jogada !== 4'b1000) begin
            errors++;
            $display("FAIL hab_on: got strobes=%0d jog=%b want 1 1000", n, jogada);
        end
        idle(10);
    endtask

    task automatic test_autorepeat();
        int n, want;
        n = 0; want = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(4'b0001);
            n += tem_jogada;
            want += rep_hit(i);
            checks++;
            if (tem_jogada !== rep_hit(i)) begin
                errors++;
                $display("FAIL repeat cyc %0d: got tem=%b want %b", i, tem_jogada, rep_hit(i));
            end
        end
        checks++;
        if (n != want || jogada !== 4'b0001) begin
            errors++;
            $display("FAIL repeat_count: got %0d jog=%b want %0d 0001", n, jogada, want);
        end
        idle(10);
    endtask

    task automatic test_random();
        logic [3:0] tab [8];
        logic [3:0] v;
        int len;
        tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0110, 4'b1111};
        for (int seg = 0; seg < 60; seg++) begin
            v = tab[$urandom_range(0, 7)];
            len = $urandom_range(1, 12);
            habilita = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < len; i++) begin
                reset = ($urandom_range(0, 99) == 0);
                cyc(v);
                checks++;
                if ({tem_jogada, jogada_invalida, jogada} !== {m_tem, m_inv, m_jog}) begin
                    errors++;
                    $display("FAIL random seg %0d: got %b%b %b want %b%b %b", seg,
                             tem_jogada, jogada_invalida, jogada, m_tem, m_inv, m_jog);
                end
            end
        end
        reset = 1'b0;
        habilita = 1'b1;
        idle(10);
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_held_through_reset();
        test_press_latency();
        test_glitch();
        test_multi();
        test_habilita();
        test_autorepeat();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
